// File: rtl/cpu_mon_pkg.sv
//==============================================================================
// Package    : cpu_mon_pkg
// Description: Shared types and constants for the CPU run monitor.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

package cpu_mon_pkg;

    typedef enum logic [0:0] {
        MON_RUN  = 1'b0,
        MON_HALT = 1'b1
    } mon_state_t;

    localparam logic [1:0] CH_DISP  = 2'd0;
    localparam logic [1:0] CH_INSTR = 2'd1;
    localparam logic [1:0] CH_JMP   = 2'd2;
    localparam logic [1:0] CH_BR    = 2'd3;

    localparam logic [31:0] SHOW_CODE_DEFAULT = 32'h0000_0022;

endpackage

`default_nettype wire

// File: rtl/cpu_run_monitor_if.sv
//==============================================================================
// Interface  : cpu_run_monitor_if
// Description: CPU-side run-control and display bus of the run monitor.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cpu_run_monitor_if #(
    parameter int DATA_W = 32
);
    logic              syscall;
    logic [DATA_W-1:0] v0;
    logic [DATA_W-1:0] a0;
    logic              jmp;
    logic              branch;
    logic              clr;
    logic [1:0]        sel;
    logic              pc_enable;
    logic              halted;
    logic [DATA_W-1:0] disp_out;

    modport master (
        output syscall, v0, a0, jmp, branch, clr, sel,
        input  pc_enable, halted, disp_out
    );

    modport slave (
        input  syscall, v0, a0, jmp, branch, clr, sel,
        output pc_enable, halted, disp_out
    );
endinterface

`default_nettype wire

// File: rtl/go_edge_sync.sv
//==============================================================================
// Module     : go_edge_sync
// Description: Multi-flop synchroniser for the raw go button with a one-cycle
//              rising-edge pulse output.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module go_edge_sync #(
    parameter int SYNC_STG = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_go,
    output logic      o_pulse
);
    logic [SYNC_STG-1:0] r_sync;
    logic                r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STG-2:0], i_go};
            r_prev <= r_sync[SYNC_STG-1];
        end
    end

    assign o_pulse = r_sync[SYNC_STG-1] & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/cpu_run_monitor.sv
//==============================================================================
// Module     : cpu_run_monitor
// Description: Syscall run control (continue/halt-until-go), retire statistics
//              and display channel mux. MON_SATURATE_EN makes counters saturate.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module cpu_run_monitor
    import cpu_mon_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                CNT_W     = 32,
    parameter logic [DATA_W-1:0] SHOW_CODE = DATA_W'(SHOW_CODE_DEFAULT),
    parameter int                SYNC_STG  = 2
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           go,
    cpu_run_monitor_if.slave    bus
);
    mon_state_t        r_state;
    mon_state_t        w_state_nxt;
    logic              w_go_pulse;
    logic              w_show;
    logic              w_halt_req;
    logic              w_pc_enable;
    logic [DATA_W-1:0] r_disp;
    logic [CNT_W-1:0]  r_instr_cnt;
    logic [CNT_W-1:0]  r_jmp_cnt;
    logic [CNT_W-1:0]  r_br_cnt;

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
`ifdef MON_SATURATE_EN
        return (&v) ? v : v + 1'b1;
`else
        return v + 1'b1;
`endif
    endfunction

    go_edge_sync #(
        .SYNC_STG (SYNC_STG)
    ) u_go_sync (
        .clk     (clk),
        .rst     (rst),
        .i_go    (go),
        .o_pulse (w_go_pulse)
    );

    assign w_show     = (bus.v0 == SHOW_CODE);
    assign w_halt_req = bus.syscall && !w_show;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MON_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The resume cycle commits the halting syscall, so it retires exactly once.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_enable = 1'b0;
        case (r_state)
            MON_RUN: begin
                w_pc_enable = !w_halt_req;
                if (w_halt_req) begin
                    w_state_nxt = MON_HALT;
                end
            end
            MON_HALT: begin
                w_pc_enable = w_go_pulse;
                if (w_go_pulse) begin
                    w_state_nxt = MON_RUN;
                end
            end
            default: begin
                w_state_nxt = MON_RUN;
            end
        endcase
    end

    // Clear wins over a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_instr_cnt <= '0;
            r_jmp_cnt   <= '0;
            r_br_cnt    <= '0;
        end else if (w_pc_enable) begin
            r_instr_cnt <= bump(r_instr_cnt);
            if (bus.jmp) begin
                r_jmp_cnt <= bump(r_jmp_cnt);
            end
            if (bus.branch) begin
                r_br_cnt <= bump(r_br_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_disp <= '0;
        end else if (w_pc_enable && bus.syscall && w_show) begin
            r_disp <= bus.a0;
        end
    end

    always_comb begin
        bus.disp_out = r_disp;
        case (bus.sel)
            CH_DISP:  bus.disp_out = r_disp;
            CH_INSTR: bus.disp_out = DATA_W'(r_instr_cnt);
            CH_JMP:   bus.disp_out = DATA_W'(r_jmp_cnt);
            CH_BR:    bus.disp_out = DATA_W'(r_br_cnt);
            default:  bus.disp_out = r_disp;
        endcase
    end

    assign bus.pc_enable = w_pc_enable;
    assign bus.halted    = (r_state == MON_HALT);

endmodule

`default_nettype wire

// File: tb/tb_cpu_run_monitor.sv
//==============================================================================
// Module     : tb_cpu_run_monitor
// Description: Directed self-checking bench for cpu_run_monitor.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cpu_run_monitor;
    import cpu_mon_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    logic go;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses;

    always #5 clk = ~clk;

    cpu_run_monitor_if #(.DATA_W(32)) bus  ();
    cpu_run_monitor_if #(.DATA_W(32)) bus4 ();

    cpu_run_monitor #(
        .DATA_W    (32),
        .CNT_W     (32),
        .SHOW_CODE (32'h22),
        .SYNC_STG  (2)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .go  (go),
        .bus (bus)
    );

    cpu_run_monitor #(
        .DATA_W    (32),
        .CNT_W     (4),
        .SHOW_CODE (32'h22),
        .SYNC_STG  (2)
    ) u_dut4 (
        .clk (clk),
        .rst (rst4),
        .go  (1'b0),
        .bus (bus4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_ch(input string tag, input logic [1:0] s, input logic [31:0] exp);
        bus.sel = s;
        #1;
        check_eq(tag, bus.disp_out, exp);
    endtask

    initial begin
        rst = 1'b1; rst4 = 1'b1; go = 1'b0;
        bus.syscall = 1'b0; bus.v0 = '0; bus.a0 = '0; bus.jmp = 1'b0;
        bus.branch = 1'b0; bus.clr = 1'b0; bus.sel = CH_DISP;
        bus4.syscall = 1'b0; bus4.v0 = '0; bus4.a0 = '0; bus4.jmp = 1'b0;
        bus4.branch = 1'b0; bus4.clr = 1'b0; bus4.sel = CH_INSTR;
        tick(); tick();

        // reset state
        check_eq("rst_halted", 32'(bus.halted), 32'd0);
        chk_ch("rst_instr", CH_INSTR, 32'd0);
        chk_ch("rst_disp", CH_DISP, 32'd0);
        chk_ch("rst_br", CH_BR, 32'd0);
        rst = 1'b0;

        // 10 plain retires: jmp on 3, taken branch on 2
        for (int i = 0; i < 10; i++) begin
            bus.jmp    = (i < 3);
            bus.branch = (i == 5 || i == 7);
            tick();
        end
        bus.jmp = 1'b0; bus.branch = 1'b0;
        chk_ch("instr_10", CH_INSTR, 32'd10);
        chk_ch("jmp_3", CH_JMP, 32'd3);
        chk_ch("br_2", CH_BR, 32'd2);

        // display-and-continue syscall
        bus.syscall = 1'b1; bus.v0 = 32'h22; bus.a0 = 32'hDEADBEEF;
        #1;
        check_eq("show_pc_en", 32'(bus.pc_enable), 32'd1);
        check_eq("show_halted", 32'(bus.halted), 32'd0);
        tick();
        bus.syscall = 1'b0;
        chk_ch("disp_val", CH_DISP, 32'hDEADBEEF);
        chk_ch("instr_11", CH_INSTR, 32'd11);

        // clear coincident with a jump retire
        bus.jmp = 1'b1;
        tick(); tick();
        chk_ch("jmp_5", CH_JMP, 32'd5);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0; bus.jmp = 1'b0;
        chk_ch("clr_jmp", CH_JMP, 32'd0);
        chk_ch("clr_instr", CH_INSTR, 32'd0);
        chk_ch("clr_br", CH_BR, 32'd0);
        chk_ch("clr_disp_kept", CH_DISP, 32'hDEADBEEF);
        tick();

        // halting syscall, go held high for 20 cycles
        bus.syscall = 1'b1; bus.v0 = 32'h0A;
        #1;
        check_eq("halt_pc_en", 32'(bus.pc_enable), 32'd0);
        tick();
        check_eq("halt_halted", 32'(bus.halted), 32'd1);
        chk_ch("halt_instr", CH_INSTR, 32'd1);
        go = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (bus.pc_enable) pulses++;
            tick();
        end
        check_eq("go_pulses", 32'(pulses), 32'd1);
        check_eq("rehalted", 32'(bus.halted), 32'd1);
        chk_ch("resume_instr", CH_INSTR, 32'd2);

        // reset while halted with go bouncing
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            go = ~go;
            tick();
        end
        check_eq("rst_halt_halted", 32'(bus.halted), 32'd0);
        chk_ch("rst_halt_instr", CH_INSTR, 32'd0);
        chk_ch("rst_halt_jmp", CH_JMP, 32'd0);
        chk_ch("rst_halt_disp", CH_DISP, 32'd0);
        bus.syscall = 1'b0; go = 1'b0; rst = 1'b0;
        tick();
        chk_ch("post_rst_instr", CH_INSTR, 32'd1);
        bus.syscall = 1'b1; bus.v0 = 32'h0A;
        tick();
        for (int i = 0; i < 5; i++) tick();
        check_eq("no_stray_halted", 32'(bus.halted), 32'd1);
        chk_ch("no_stray_instr", CH_INSTR, 32'd1);

        // narrow counter wrap / saturate
        rst4 = 1'b0;
        for (int i = 0; i < 17; i++) tick();
`ifdef MON_SATURATE_EN
        check_eq("cnt4_17", bus4.disp_out, 32'd15);
`else
        check_eq("cnt4_17", bus4.disp_out, 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
